// File: rtl/rv_ctrl_pkg.sv
// Shared state, opcode and control-field encodings for the multi-cycle RV32I
// main control FSM and its memory wait timer.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXEC_R,
    EXEC_I,
    ALUWB,
    BRANCH,
    TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_ADDI = 3'b000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_RS1  = 2'b01;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_wait_state(state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles within one FSM state and flags the cycle on
// which the wait budget is used up.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  input  logic clear,
  output logic timeout
);

  localparam int            CW   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] FULL = CW'(MEM_TIMEOUT);

  logic [CW-1:0] cnt;
  logic          stall;

  assign stall = waiting && !mem_ready;

  // cnt holds the stalls already seen, so cnt == N-1 makes this stall the N-th;
  // a ready memory in that cycle never times out because stall is low.
  assign timeout = stall && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (stall && (cnt != FULL)) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Multi-cycle RV32I main control: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables and the aluop code, and traps on illegal ops or memory stalls.
module multicycle_main_control
  import rv_ctrl_pkg::*;
#(
  parameter int ENABLE_ADDI = 1,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       fault,
  output logic [1:0] fault_code
);

  state_t     state;
  state_t     state_nxt;
  ctrl_t      ctrl;
  logic [1:0] fc_nxt;
  logic       fault_q;
  logic [1:0] fault_code_q;
  logic       timeout;

  function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] f3);
    state_t s;
    s = TRAP;
    case (op)
      OP_R:              s = EXEC_R;
      OP_LOAD, OP_STORE: if (f3 == F3_WORD) s = MEMADR;
      OP_BRANCH:         if (f3 == F3_BEQ) s = BRANCH;
      OP_I:              if ((ENABLE_ADDI != 0) && (f3 == F3_ADDI)) s = EXEC_I;
      default:           s = TRAP;
    endcase
    return s;
  endfunction

  generate
    if (MEM_TIMEOUT > 0) begin : g_timer
      logic waiting;
      logic clear;

      assign waiting = is_wait_state(state);
      assign clear   = (state_nxt != state);

      mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
      ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .waiting  (waiting),
        .mem_ready(mem_ready),
        .clear    (clear),
        .timeout  (timeout)
      );
    end else begin : g_no_timer
      assign timeout = 1'b0;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    fc_nxt    = FAULT_NONE;
    ctrl      = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        if (mem_ready) begin
          state_nxt = DECODE;
        end else if (timeout) begin
          state_nxt = TRAP;
          fc_nxt    = FAULT_TIMEOUT;
        end
      end
      DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
        state_nxt      = decode_next(opcode, funct3);
        if (state_nxt == TRAP) fc_nxt = FAULT_ILLEGAL;
      end
      MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
        state_nxt      = (opcode == OP_STORE) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready) begin
          state_nxt = MEMWB;
        end else if (timeout) begin
          state_nxt = TRAP;
          fc_nxt    = FAULT_TIMEOUT;
        end
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
        state_nxt       = FETCH;
      end
      MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
        if (mem_ready) begin
          state_nxt = FETCH;
        end else if (timeout) begin
          state_nxt = TRAP;
          fc_nxt    = FAULT_TIMEOUT;
        end
      end
      EXEC_R: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.aluop     = ALUOP_FUNCT;
        state_nxt      = ALUWB;
      end
      EXEC_I: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
        state_nxt      = ALUWB;
      end
      ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_nxt       = FETCH;
      end
      BRANCH: begin
        ctrl.alu_src_a     = SRCA_RS1;
        ctrl.alu_src_b     = SRCB_RS2;
        ctrl.aluop         = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
        ctrl.instr_done    = 1'b1;
        state_nxt          = FETCH;
      end
      TRAP: begin
        state_nxt = TRAP;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
    // Reset abandons the current instruction: no request or write escapes
    if (reset) begin
      ctrl      = '0;
      state_nxt = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      fault_q      <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state <= state_nxt;
      if ((state != TRAP) && (state_nxt == TRAP)) begin
        fault_q      <= 1'b1;
        fault_code_q <= fc_nxt;
      end
    end
  end

  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign iord          = ctrl.iord;
  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign aluop         = ctrl.aluop;
  assign reg_write     = ctrl.reg_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign instr_done    = ctrl.instr_done;
  assign fault         = fault_q;
  assign fault_code    = fault_code_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: each instruction is expanded into a
// cycle-by-cycle schedule of expected outputs and mem_ready values.
module tb_multicycle_main_control;

  localparam int TMO = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source;
  logic [1:0] alu_src_a, alu_src_b, aluop;
  logic       reg_write, mem_to_reg, instr_done, fault;
  logic [1:0] fault_code;

  multicycle_main_control #(
    .ENABLE_ADDI(1),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct3       (funct3),
    .mem_ready    (mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .iord         (iord),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_source    (pc_source),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .aluop        (aluop),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .instr_done   (instr_done),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source;
    logic [1:0] alu_src_a, alu_src_b, aluop;
    logic       reg_write, mem_to_reg, instr_done, fault;
    logic [1:0] fault_code;
  } obs_t;

  obs_t got;
  assign got = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source,
                alu_src_a, alu_src_b, aluop, reg_write, mem_to_reg, instr_done, fault, fault_code};

  // Phases of an instruction as seen from the datapath
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
                 P_MEMWR = 5, P_EXEC_R = 6, P_EXEC_I = 7, P_ALUWB = 8, P_BRANCH = 9,
                 P_TRAP = 10;
  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_ILL = 5;

  obs_t       exp_q[$];
  logic       rdy_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       mdl_fault;
  logic [1:0] mdl_code;
  bit         trapped;

  function automatic obs_t ph(int kind, logic r, logic [1:0] code);
    obs_t o;
    o = '0;
    case (kind)
      P_FETCH:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = r; o.pc_write = r; end
      P_DECODE: o.alu_src_b = 2'b10;
      P_MEMADR: begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; end
      P_MEMRD:  begin o.mem_read = 1; o.iord = 1; end
      P_MEMWB:  begin o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1; end
      P_MEMWR:  begin o.mem_write = 1; o.iord = 1; o.instr_done = r; end
      P_EXEC_R: begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b00; o.aluop = 2'b10; end
      P_EXEC_I: begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; end
      P_ALUWB:  begin o.reg_write = 1; o.instr_done = 1; end
      P_BRANCH: begin
        o.alu_src_a = 2'b01; o.aluop = 2'b01; o.pc_write_cond = 1; o.pc_source = 1;
        o.instr_done = 1;
      end
      P_TRAP:   begin o.fault = 1; o.fault_code = code; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic int classify(logic [6:0] o, logic [2:0] f);
    if (o == 7'b0110011) return C_R;
    if ((o == 7'b0000011) && (f == 3'b010)) return C_LW;
    if ((o == 7'b0100011) && (f == 3'b010)) return C_SW;
    if ((o == 7'b1100011) && (f == 3'b000)) return C_BEQ;
    if ((o == 7'b0010011) && (f == 3'b000)) return C_I;
    return C_ILL;
  endfunction

  task automatic push(obs_t e, logic r);
    exp_q.push_back(e);
    rdy_q.push_back(r);
  endtask

  task automatic push_any(obs_t e);
    push(e, 1'($urandom_range(0, 1)));
  endtask

  task automatic add_trap(logic [1:0] code, int n);
    for (int i = 0; i < n; i++) push_any(ph(P_TRAP, 1'b0, code));
    trapped   = 1;
    mdl_fault = 1'b1;
    mdl_code  = code;
  endtask

  // A memory phase stalls `waits` cycles; the TMO-th stall ends in a trap
  task automatic add_wait(int kind, int waits, output bit hit);
    hit = 0;
    for (int i = 0; i < waits; i++) begin
      push(ph(kind, 1'b0, 2'b00), 1'b0);
      if (i + 1 == TMO) begin
        hit = 1;
        return;
      end
    end
    push(ph(kind, 1'b1, 2'b00), 1'b1);
  endtask

  task automatic build(int cls, int fw, int mw, int hold);
    bit hit;
    trapped = 0;
    add_wait(P_FETCH, fw, hit);
    if (hit) begin
      add_trap(2'b10, hold);
      return;
    end
    push_any(ph(P_DECODE, 1'b0, 2'b00));
    case (cls)
      C_R:   begin push_any(ph(P_EXEC_R, 1'b0, 2'b00)); push_any(ph(P_ALUWB, 1'b0, 2'b00)); end
      C_I:   begin push_any(ph(P_EXEC_I, 1'b0, 2'b00)); push_any(ph(P_ALUWB, 1'b0, 2'b00)); end
      C_LW: begin
        push_any(ph(P_MEMADR, 1'b0, 2'b00));
        add_wait(P_MEMRD, mw, hit);
        if (hit) add_trap(2'b10, hold);
        else push_any(ph(P_MEMWB, 1'b0, 2'b00));
      end
      C_SW: begin
        push_any(ph(P_MEMADR, 1'b0, 2'b00));
        add_wait(P_MEMWR, mw, hit);
        if (hit) add_trap(2'b10, hold);
      end
      C_BEQ: push_any(ph(P_BRANCH, 1'b0, 2'b00));
      default: add_trap(2'b01, hold);
    endcase
  endtask

  task automatic run(string tag);
    obs_t e;
    int   cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e         = exp_q.pop_front();
      mem_ready = rdy_q.pop_front();
      @(negedge clk);
      checks++;
      assert (got === e) else begin
        errors++;
        $error("FAIL %s cyc %0d got %h expected %h", tag, cyc, got, e);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset(int n);
    obs_t e;
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = '0;
      if (i == 0) begin
        e.fault      = mdl_fault;
        e.fault_code = mdl_code;
      end
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      assert (got === e) else begin
        errors++;
        $error("FAIL reset cyc %0d got %h expected %h", i, got, e);
      end
      @(posedge clk);
      #1;
    end
    reset     = 1'b0;
    mdl_fault = 1'b0;
    mdl_code  = 2'b00;
  endtask

  task automatic instr(logic [6:0] o, logic [2:0] f, int fw, int mw, int hold, string tag);
    opcode = o;
    funct3 = f;
    build(classify(o, f), fw, mw, hold);
    run(tag);
    if (trapped) do_reset(1);
  endtask

  initial begin
    obs_t       dummy_e;
    logic       dummy_r;
    int         sel, fw, mw;
    logic [6:0] o;
    logic [2:0] f;

    reset     = 1'b1;
    mem_ready = 1'b0;
    opcode    = 7'b0;
    funct3    = 3'b0;
    mdl_fault = 1'b0;
    mdl_code  = 2'b00;
    @(posedge clk);
    #1;
    do_reset(2);

    instr(7'b0110011, 3'b000, 0, 0, 0, "add");
    instr(7'b0000011, 3'b010, 0, 2, 0, "lw_wait2");
    instr(7'b1100011, 3'b000, 0, 0, 0, "beq");
    instr(7'b0100011, 3'b010, 1, 1, 0, "sw_wait");
    instr(7'b0010011, 3'b000, 2, 0, 0, "addi");
    instr(7'b1110011, 3'b000, 0, 0, 20, "illegal_system");
    instr(7'b0000011, 3'b000, 0, 0, 3, "illegal_lb");
    instr(7'b0010011, 3'b001, 0, 0, 3, "illegal_slli");
    instr(7'b1100011, 3'b001, 0, 0, 3, "illegal_bne");
    instr(7'b0110011, 3'b000, 3, 0, 5, "fetch_timeout");
    instr(7'b0110011, 3'b000, 2, 0, 0, "fetch_ready_c3");
    instr(7'b0000011, 3'b010, 0, 3, 4, "memrd_timeout");
    instr(7'b0100011, 3'b010, 0, 3, 4, "memwr_timeout");
    instr(7'b0000011, 3'b010, 1, 2, 0, "lw_ready_c3");

    // Store abandoned by reset while stalled in its memory write
    opcode = 7'b0100011;
    funct3 = 3'b010;
    build(C_SW, 0, 2, 0);
    dummy_e = exp_q.pop_back();
    dummy_r = rdy_q.pop_back();
    run("sw_abort");
    do_reset(1);
    instr(7'b0110011, 3'b111, 0, 0, 0, "after_abort");

    for (int k = 0; k < 80; k++) begin
      sel = int'($urandom_range(0, 6));
      f   = 3'($urandom_range(0, 7));
      case (sel)
        0:       o = 7'b0110011;
        1:       begin o = 7'b0010011; f = 3'b000; end
        2:       begin o = 7'b0000011; f = 3'b010; end
        3:       begin o = 7'b0100011; f = 3'b010; end
        4:       begin o = 7'b1100011; f = 3'b000; end
        5:       o = 7'($urandom);
        default: o = 7'b0110011;
      endcase
      fw = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      mw = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      instr(o, f, fw, mw, 3, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
